hamming_out_mux: RTL and testbench
==================================

Name: hamming_out_mux

Overview:
- Registered 4-to-1 output selector for the Hamming (7,4) decoder datapath.
- Picks one of three sources for the 4-bit display/output bus:
  - the corrected data nibble,
  - the data bits of the received (erroneous) word,
  - the syndrome bits.
- Sits between the syndrome/correction logic and the display driver.
- The output is registered on the single system clock.

Parameters:
- RST_VAL, 4'b0000, value loaded into s_mux on reset and driven for the unused select code.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- e_mux  input  2  source select code.
- corregido  input  4  corrected data nibble [3:0].
- s1  input  1  syndrome bit 1.
- s2  input  1  syndrome bit 2.
- s3  input  1  syndrome bit 3.
- p_error  input  8  received word; bit index = Hamming position, bit 0 unused.
- s_mux  output  4  selected nibble, registered.

Behaviour:
- Reset:
  - rst high forces s_mux = RST_VAL immediately, with no clock needed.
  - s_mux holds RST_VAL while rst is high.
  - On release, s_mux updates at the first rising clk edge with rst low.
- Latency: exactly 1 clk cycle. s_mux after edge N reflects the inputs sampled at edge N.
- Selection, evaluated combinationally and registered:
  - e_mux = 2'b01: next s_mux = corregido[3:0], passed through unchanged.
  - e_mux = 2'b10: next s_mux = {p_error[7], p_error[6], p_error[5], p_error[3]}. These are the data positions, MSB = position 7.
  - e_mux = 2'b11: next s_mux = {1'b0, s3, s2, s1}.
  - e_mux = 2'b00: next s_mux = RST_VAL (default 0000).
  - Any X/Z on e_mux: next s_mux = RST_VAL. The case statement must carry a default.
- Unused inputs: p_error[4], p_error[2], p_error[1] and p_error[0] are ignored.
- No handshake: a new selection is taken every cycle, and inputs may change every cycle.
- Simultaneous events: if rst rises in the same cycle as a select change, reset wins and s_mux = RST_VAL.
- Reset mid-operation: asserting rst mid-operation discards the pending value, with no glitch to any non-RST_VAL value.
- No internal state other than the s_mux register (plus the optional flag register).

Optional Feature:
- Macro: HAMMING_MUX_ERRFLAG_EN.
- When defined:
  - Adds output err_flag (1 bit, registered, same latency as s_mux).
  - err_flag = s1 | s2 | s3, sampled every cycle regardless of e_mux.
  - Reset value 0.
- When not defined:
  - The port and its register are absent.
  - Behaviour of s_mux is identical in both builds.

Test Plan:
- Reset: hold rst=1 with inputs non-zero, then release -> s_mux = 0000 asynchronously during reset, without waiting for a clk edge.
- Corrected path: corregido=1010, e_mux=01 -> s_mux = 1010 one cycle later.
- Error-word path: p_error=11001100, e_mux=10 -> s_mux = 1101 one cycle later.
- Syndrome path: s1=1, s2=0, s3=1, e_mux=11 -> s_mux = 0101. Also check s1=s2=s3=1 -> 0111.
- Default and mid-op reset:
  - e_mux=00 with all inputs non-zero -> s_mux = 0000.
  - Assert rst between clock edges while e_mux=01 -> s_mux drops to 0000 immediately.
  - First edge after release -> s_mux = 1010.
- Feature build (HAMMING_MUX_ERRFLAG_EN): s1=s2=s3=0 -> err_flag=0; s2=1 -> err_flag=1 one cycle later; reset -> err_flag=0.

Source files
------------

// File: rtl/hamming_out_mux_if.sv
// Bus between the Hamming (7,4) syndrome/correction logic and the registered output selector.
// With HAMMING_MUX_ERRFLAG_EN defined, the bus also carries the registered err_flag.
interface hamming_out_mux_if;
   logic [1:0] e_mux;
   logic [3:0] corregido;
   logic       s1;
   logic       s2;
   logic       s3;
   logic [7:0] p_error;
   logic [3:0] s_mux;
`ifdef HAMMING_MUX_ERRFLAG_EN
   logic       err_flag;
`endif

   // The master drives the selection sources. The slave is the selector itself.
   modport master (
      output e_mux, corregido, s1, s2, s3, p_error,
`ifdef HAMMING_MUX_ERRFLAG_EN
      input  err_flag,
`endif
      input  s_mux
   );

   modport slave (
      input  e_mux, corregido, s1, s2, s3, p_error,
`ifdef HAMMING_MUX_ERRFLAG_EN
      output err_flag,
`endif
      output s_mux
   );
endinterface

// File: rtl/hamming_out_mux.sv
// Registered 4-to-1 output selector for the Hamming (7,4) decoder display bus.
// Optional macro HAMMING_MUX_ERRFLAG_EN adds a registered err_flag (s1 | s2 | s3).
module hamming_out_mux #(
   parameter logic [3:0] RST_VAL = 4'b0000
) (
   input  logic              clk,
   input  logic              rst,
   hamming_out_mux_if.slave  bus
);

   logic [3:0] next_s_mux;

   // Codes 00 and any unknown code fall back to RST_VAL. Code 10 picks the
   // data positions 7,6,5,3 of the received word, so positions 4,2,1,0 are ignored.
   always_comb begin
      next_s_mux = RST_VAL;
      case (bus.e_mux)
         2'b01:   next_s_mux = bus.corregido;
         2'b10:   next_s_mux = {bus.p_error[7], bus.p_error[6], bus.p_error[5], bus.p_error[3]};
         2'b11:   next_s_mux = {1'b0, bus.s3, bus.s2, bus.s1};
         default: next_s_mux = RST_VAL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.s_mux <= RST_VAL;
      end else begin
         bus.s_mux <= next_s_mux;
      end
   end

`ifdef HAMMING_MUX_ERRFLAG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.err_flag <= 1'b0;
      end else begin
         bus.err_flag <= bus.s1 | bus.s2 | bus.s3;
      end
   end
`endif

endmodule

// File: tb/tb_hamming_out_mux.sv
// Directed bench for hamming_out_mux: reset, each select path, fallback codes, mid-run reset.
// Also checks err_flag when built with HAMMING_MUX_ERRFLAG_EN.
module tb_hamming_out_mux;

   logic clk;
   logic rst;
   int   n_vectors;
   int   n_miscompares;

   hamming_out_mux_if bus ();

   hamming_out_mux #(.RST_VAL(4'b0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge so they are stable at the sampling edge.
   task automatic apply_stimulus(input logic [1:0] e, input logic [3:0] c,
                                 input logic v1, input logic v2, input logic v3,
                                 input logic [7:0] p);
      @(negedge clk);
      bus.e_mux     = e;
      bus.corregido = c;
      bus.s1        = v1;
      bus.s2        = v2;
      bus.s3        = v3;
      bus.p_error   = p;
   endtask

   task automatic check_output(input string tag, input logic [3:0] expected);
      n_vectors++;
      assert (bus.s_mux === expected) else begin
         n_miscompares++;
         $error("[TB] FAIL %s: s_mux observed %b expected %b", tag, bus.s_mux, expected);
      end
   endtask

`ifdef HAMMING_MUX_ERRFLAG_EN
   task automatic check_flag(input string tag, input logic expected);
      n_vectors++;
      assert (bus.err_flag === expected) else begin
         n_miscompares++;
         $error("[TB] FAIL %s: err_flag observed %b expected %b", tag, bus.err_flag, expected);
      end
   endtask
`endif

   task automatic sample_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      rst           = 1'b0;
      bus.e_mux     = 2'b01;
      bus.corregido = 4'b1111;
      bus.s1        = 1'b1;
      bus.s2        = 1'b1;
      bus.s3        = 1'b1;
      bus.p_error   = 8'hFF;

      sample_edge();
      sample_edge();
      check_output("pre_reset_pass", 4'b1111);

      // Reset raised between edges with non-zero inputs must clear s_mux at once.
      #2;
      rst = 1'b1;
      #1;
      check_output("async_reset", 4'b0000);
`ifdef HAMMING_MUX_ERRFLAG_EN
      check_flag("async_reset_flag", 1'b0);
`endif
      sample_edge();
      check_output("reset_hold", 4'b0000);

      apply_stimulus(2'b01, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      sample_edge();
      check_output("corr_1010", 4'b1010);

      apply_stimulus(2'b01, 4'b0101, 1'b1, 1'b1, 1'b1, 8'hFF);
      sample_edge();
      check_output("corr_0101", 4'b0101);

      apply_stimulus(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 8'b11001100);
      sample_edge();
      check_output("perr_11001100", 4'b1101);

      apply_stimulus(2'b10, 4'b1111, 1'b1, 1'b1, 1'b1, 8'b10101000);
      sample_edge();
      check_output("perr_10101000", 4'b1011);

      apply_stimulus(2'b10, 4'b1111, 1'b1, 1'b1, 1'b1, 8'b00010111);
      sample_edge();
      check_output("perr_unused_bits", 4'b0000);

      apply_stimulus(2'b11, 4'b1111, 1'b1, 1'b0, 1'b1, 8'hFF);
      sample_edge();
      check_output("synd_101", 4'b0101);

      apply_stimulus(2'b11, 4'b0000, 1'b1, 1'b1, 1'b1, 8'h00);
      sample_edge();
      check_output("synd_111", 4'b0111);

      apply_stimulus(2'b11, 4'b1111, 1'b0, 1'b1, 1'b0, 8'hFF);
      sample_edge();
      check_output("synd_010", 4'b0010);

      apply_stimulus(2'b00, 4'b1111, 1'b1, 1'b1, 1'b1, 8'hFF);
      sample_edge();
      check_output("sel_00_default", 4'b0000);

      apply_stimulus(2'b01, 4'b0110, 1'b0, 1'b0, 1'b0, 8'h00);
      sample_edge();
      check_output("corr_0110", 4'b0110);

      apply_stimulus(2'bxx, 4'b1111, 1'b1, 1'b1, 1'b1, 8'hFF);
      sample_edge();
      check_output("sel_unknown", 4'b0000);

      // Reset raised together with a select change: reset wins.
      apply_stimulus(2'b01, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
      sample_edge();
      check_output("corr_before_midreset", 4'b1010);
      @(negedge clk);
      rst           = 1'b1;
      bus.e_mux     = 2'b11;
      bus.s1        = 1'b1;
      #1;
      check_output("midop_reset_async", 4'b0000);
      sample_edge();
      check_output("midop_reset_hold", 4'b0000);

      apply_stimulus(2'b01, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      sample_edge();
      check_output("first_edge_after_release", 4'b1010);

`ifdef HAMMING_MUX_ERRFLAG_EN
      apply_stimulus(2'b01, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
      sample_edge();
      check_flag("flag_clear", 1'b0);

      apply_stimulus(2'b00, 4'b1010, 1'b0, 1'b1, 1'b0, 8'h00);
      sample_edge();
      check_flag("flag_s2", 1'b1);
      check_output("flag_s2_mux", 4'b0000);

      apply_stimulus(2'b10, 4'b1010, 1'b0, 1'b0, 1'b1, 8'h00);
      sample_edge();
      check_flag("flag_s3", 1'b1);

      #2;
      rst = 1'b1;
      #1;
      check_flag("flag_reset", 1'b0);
      apply_stimulus(2'b01, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      sample_edge();
      check_flag("flag_after_release", 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: simulation exceeded time budget");
      $fatal(1, "[TB] timeout");
   end

endmodule
